sfifo_flags: RTL
================

# sfifo_flags

Parametrised synchronous data FIFO, next generation of the team's basic FIFO: adds asynchronous active-low reset, synchronous flush, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags and write-through-on-full. It sits between a producer and a consumer in the same clock domain (UART/bus bridges, stream buffering). Read-port mode, registered or first-word-fall-through, is selected at compile time.

## Interface
- BW, 8, data width in bits (≥1)
- LGFLEN, 4, log2 of depth; depth = 2^LGFLEN entries (≥1)
- AF_THRESH, (1<<LGFLEN)-2, o_almost_full asserts when fill ≥ AF_THRESH; legal 1..2^LGFLEN
- AE_THRESH, 2, o_almost_empty asserts when fill ≤ AE_THRESH; legal 0..2^LGFLEN-1
- i_clk  in  1  clock, all state on rising edge
- i_reset_n  in  1  reset, asynchronous assert, active-low
- i_flush  in  1  synchronous clear of contents and error flags
- i_wr  in  1  write request
- i_data  in  BW  write data
- o_full  out  1  fill == 2^LGFLEN
- o_almost_full  out  1  fill ≥ AF_THRESH
- o_fill  out  LGFLEN+1  current entry count, 0..2^LGFLEN
- o_overflow  out  1  sticky: a write was dropped
- i_rd  in  1  read request
- o_data  out  BW  read data (mode-dependent, see Configuration)
- o_rd_valid  out  1  o_data valid qualifier
- o_empty  out  1  fill == 0
- o_almost_empty  out  1  fill ≤ AE_THRESH
- o_underflow  out  1  sticky: a read hit an empty FIFO

## Operation
- Pointers wr_addr, rd_addr are LGFLEN+1 bits; low LGFLEN bits index memory; MSB disambiguates full/empty. fill = wr_addr − rd_addr, modulo 2^(LGFLEN+1).
- w_rd = i_rd && !o_empty.
- w_wr = i_wr && (!o_full || w_rd): a write on a full FIFO is accepted when a read is accepted in the same cycle (fill unchanged).
- Write on empty with simultaneous read: read rejected (underflow set), write accepted, fill becomes 1.
- Overflow set when i_wr && !w_wr; underflow set when i_rd && o_empty. Both stay set until flush or reset.
- i_flush: pointers → 0, o_overflow/o_underflow → 0, i_wr/i_rd in that cycle ignored and flag no error. Memory contents not cleared.
- Pointers wrap naturally at 2^(LGFLEN+1); no saturation logic.
- Status outputs (o_full, o_empty, o_fill, almost flags) are combinational from the registered pointers.

## Timing
- Reset (i_reset_n low, any time, mid-transfer included): pointers 0, o_fill 0, o_empty 1, o_almost_empty 1, o_full 0, o_almost_full 0 (AF_THRESH ≥ 1), o_overflow 0, o_underflow 0, o_rd_valid 0, o_data 0 in registered mode.
- Write latency: data accepted at edge N is readable (o_empty low) after edge N.
- Registered mode: w_rd at edge N → o_data holds that entry and o_rd_valid is high for exactly the cycle after N; o_data holds its value otherwise.
- Flags update on the edge following the causing request.

## Configuration
- SFIFO_FWFT_EN defined: first-word-fall-through; o_data = mem[rd_addr] combinationally, o_rd_valid = !o_empty; i_rd acknowledges/pops the displayed word; zero read latency.
- SFIFO_FWFT_EN undefined: registered read as in Timing; one-cycle read latency; o_data register reset to 0.

## Structure
- Shared package sfifo_pkg: pointer-width function (LGFLEN+1), fill-compare helper, threshold legality checks (elaboration-time error on illegal AF_THRESH/AE_THRESH).
- One sub-module sfifo_mem: 2^LGFLEN × BW array, one write port, one read port (async read for FWFT, registered read otherwise); no reset on the array.

## Test plan
- Reset, write 0x11,0x22,0x33, read 3 → data 0x11,0x22,0x33 in order; o_fill 3→0; registered mode: each o_rd_valid one cycle after its i_rd.
- Fill 16 entries (LGFLEN=4), write 0xAA alone → o_full=1, o_overflow=1, fill stays 16; then i_wr+i_rd together with 0xBB → both accepted, fill 16, 0xBB is last word read.
- Empty FIFO, i_rd → o_underflow=1; i_wr 0x5A + i_rd same cycle → fill 1, 0x5A read next.
- Step fill 0→16 with AF_THRESH=14, AE_THRESH=2 → o_almost_empty high for fill 0..2, o_almost_full high for fill 14..16.
- Fill 9, set both error flags, pulse i_flush with i_wr → fill 0, flags 0, write dropped without overflow.
- Write 40 words/read interleaved for pointer wrap, assert i_reset_n low mid-stream → all outputs at reset values same cycle, clean operation after release.

Source files
------------

// File: rtl/sfifo_pkg.sv
// Shared sizing and flag helpers for the sfifo family.
package sfifo_pkg;

  function automatic int ptr_w(input int lgflen);
    return lgflen + 1;
  endfunction

  function automatic logic fill_ge(input int fill, input int thresh);
    return fill >= thresh;
  endfunction

  function automatic logic fill_le(input int fill, input int thresh);
    return fill <= thresh;
  endfunction

  function automatic bit af_legal(input int lgflen, input int thresh);
    return (thresh >= 1) && (thresh <= (1 << lgflen));
  endfunction

  function automatic bit ae_legal(input int lgflen, input int thresh);
    return (thresh >= 0) && (thresh <= (1 << lgflen) - 1);
  endfunction

endpackage

// File: rtl/sfifo_mem.sv
// Storage array for sfifo_flags: one write port, one read port; array itself is never reset.
// Latency: async read with SFIFO_FWFT_EN, else one-cycle registered read (output reg resets to 0).
// Backpressure: none; the caller only enables ports for accepted transfers.
module sfifo_mem #(
  parameter int BW = 8,
  parameter int AW = 4
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [BW-1:0] wr_dat,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [BW-1:0] rd_dat
);

  logic [BW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wr_addr] <= wr_dat;
  end

`ifdef SFIFO_FWFT_EN
  logic unused_ok;
  assign unused_ok = &{1'b0, i_reset_n, rd_en};
  assign rd_dat = mem[rd_addr];
`else
  // Read-before-write on a same-address collision returns the old word.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)  rd_dat <= '0;
    else if (rd_en)  rd_dat <= mem[rd_addr];
  end
`endif

endmodule

// File: rtl/sfifo_flags.sv
// Synchronous FIFO with flush, almost-full/empty thresholds and sticky error flags.
// Latency: write visible after its edge; read 1 cycle (registered) or 0 with SFIFO_FWFT_EN.
// Backpressure: writes on full are dropped (overflow) unless a read is accepted the same cycle.
module sfifo_flags
  import sfifo_pkg::*;
#(
  parameter int BW        = 8,
  parameter int LGFLEN    = 4,
  parameter int AF_THRESH = (1 << LGFLEN) - 2,
  parameter int AE_THRESH = 2
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_flush,
  input  logic            i_wr,
  input  logic [BW-1:0]   i_data,
  output logic            o_full,
  output logic            o_almost_full,
  output logic [LGFLEN:0] o_fill,
  output logic            o_overflow,
  input  logic            i_rd,
  output logic [BW-1:0]   o_data,
  output logic            o_rd_valid,
  output logic            o_empty,
  output logic            o_almost_empty,
  output logic            o_underflow
);

  localparam int PW    = ptr_w(LGFLEN);
  localparam int DEPTH = 1 << LGFLEN;

  if (!af_legal(LGFLEN, AF_THRESH)) begin : g_bad_af
    $error("sfifo_flags: AF_THRESH out of range");
  end
  if (!ae_legal(LGFLEN, AE_THRESH)) begin : g_bad_ae
    $error("sfifo_flags: AE_THRESH out of range");
  end

  logic [PW-1:0] wr_addr, rd_addr;
  logic          w_wr, w_rd;

  assign o_fill         = wr_addr - rd_addr;
  assign o_full         = (o_fill == PW'(DEPTH));
  assign o_empty        = (o_fill == '0);
  assign o_almost_full  = fill_ge(int'(o_fill), AF_THRESH);
  assign o_almost_empty = fill_le(int'(o_fill), AE_THRESH);

  assign w_rd = i_rd && !o_empty;
  assign w_wr = i_wr && (!o_full || w_rd);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_addr     <= '0;
      rd_addr     <= '0;
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else if (i_flush) begin
      wr_addr     <= '0;
      rd_addr     <= '0;
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      if (w_wr)          wr_addr     <= wr_addr + PW'(1);
      if (w_rd)          rd_addr     <= rd_addr + PW'(1);
      if (i_wr && !w_wr) o_overflow  <= 1'b1;
      if (i_rd && o_empty) o_underflow <= 1'b1;
    end
  end

  sfifo_mem #(.BW(BW), .AW(LGFLEN)) u_mem (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .wr_en     (w_wr && !i_flush),
    .wr_addr   (wr_addr[LGFLEN-1:0]),
    .wr_dat    (i_data),
    .rd_en     (w_rd && !i_flush),
    .rd_addr   (rd_addr[LGFLEN-1:0]),
    .rd_dat    (o_data)
  );

`ifdef SFIFO_FWFT_EN
  assign o_rd_valid = !o_empty;
`else
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)   o_rd_valid <= 1'b0;
    else if (i_flush) o_rd_valid <= 1'b0;
    else              o_rd_valid <= w_rd;
  end
`endif

endmodule
